uart_frame_parser: RTL
======================

Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART byte receiver and consumes its single-cycle valid/byte output.
- Assembles bytes into framed command packets: sync byte, length byte, payload bytes, checksum byte.
- Buffers the payload until the checksum is verified, then replays it on a valid/ready stream to the command logic.
- Flags bad frames and never forwards them.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes per frame; buffer depth. Range 1..255.
- TIMEOUT_CYCLES, 1_000_000, idle clock cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- valid_in  input  1  one-cycle pulse; data_in holds a received byte
- data_in  input  8  received byte, sampled only when valid_in=1
- out_valid  output  1  payload byte available on out_data
- out_data  output  8  payload byte
- out_last  output  1  marks the final payload byte of a frame; qualified by out_valid
- out_ready  input  1  consumer accepts the byte when out_valid & out_ready
- frame_done  output  1  one-cycle pulse after the last byte of a good frame is accepted
- frame_err  output  1  one-cycle pulse when a frame is discarded
- err_code  output  2  cause of the discard, held until the next frame_err: 0 none, 1 bad checksum, 2 length > MAX_LEN, 3 timeout

Behaviour:
- Reset (synchronous, rst_in=1 at clk_in edge):
  - State goes to HUNT; buffer pointers, checksum and timeout counter clear.
  - out_valid, out_last, frame_done, frame_err = 0; out_data = 0; err_code = 0.
  - Reset mid-frame or mid-emit drops everything without raising any error pulse.
- Checksum: 8-bit sum, mod 256, of the length byte and all payload bytes. The frame is good iff (sum + check byte) mod 256 == 0.
- States:
  - HUNT: ignore every byte except SYNC_BYTE. On SYNC_BYTE go to LEN.
  - LEN: next byte is N.
    - N > MAX_LEN: frame_err, err_code=2, go to HUNT.
    - N == 0: go to CHECK.
    - Otherwise store N, sum=N, wr_ptr=0, go to PAYLOAD.
  - PAYLOAD: each byte is written to buffer[wr_ptr], wr_ptr++, sum += byte. After the Nth byte go to CHECK.
  - CHECK: next byte is the check byte.
    - Good frame with N>0: go to EMIT.
    - Good frame with N==0: frame_done pulse the next cycle, go to HUNT.
    - Bad frame: frame_err, err_code=1, go to HUNT.
  - EMIT: present buffer[rd_ptr] on out_data with out_valid=1 and out_last=(rd_ptr==N-1).
    - Advance only on out_valid & out_ready; out_data and out_last stay stable while stalled.
    - When the last byte is accepted: out_valid drops the next cycle, frame_done pulses that same cycle, go to HUNT.
- Latency:
  - First payload byte appears on out_valid exactly 1 cycle after the cycle in which valid_in carries the check byte.
  - Back-to-back acceptance sustains 1 byte/cycle.
- Timeout:
  - Applies in LEN, PAYLOAD and CHECK only. The counter resets on every valid_in and increments otherwise.
  - On reaching TIMEOUT_CYCLES-1: frame_err, err_code=3, go to HUNT.
- Bytes arriving during EMIT are dropped, with no error pulse. Upstream byte spacing makes this rare; the command protocol forbids it.
- A SYNC_BYTE value inside LEN/PAYLOAD/CHECK is ordinary data; there is no resynchronisation mid-frame.
- frame_err and frame_done are never asserted in the same cycle.
- valid_in in the same cycle as a state transition is processed by the current state only.

Test Plan:
- Good frame: bytes A5 03 11 22 33 97, out_ready=1 -> out_data 11,22,33 on consecutive cycles; out_last only on 33; frame_done pulse once; frame_err never.
- Backpressure: same frame, out_ready low for 5 cycles after out_valid rises, then toggling 1/0 -> each byte held stable until accepted; order 11,22,33; exactly 3 handshakes.
- Bad checksum: A5 02 10 20 00 -> no out_valid; frame_err pulse with err_code=1. A following good frame A5 01 7F 80 -> out_data 7F with out_last=1, then frame_done.
- Length violation and hunt: leading garbage 00 FF, then A5 11 (17 > MAX_LEN=16) -> frame_err, err_code=2; later A5 00 00 -> frame_done with no out_valid.
- Timeout: TIMEOUT_CYCLES=100; send A5 02 44 then silence -> frame_err at the 100th idle cycle with err_code=3. The next valid frame parses normally.
- Reset mid-emit: assert rst_in while out_valid=1 on byte 2 of 3 -> next cycle out_valid=0 and err_code=0, no pulses; the parser accepts a fresh frame immediately.

Source files
------------

// File: rtl/uart_frame_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_frame_parser                                             |
// | Function : Frames UART bytes (sync, length, payload, checksum).          |
// |            Buffers the payload until verified, then replays it.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int c_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      c_MAX_LEN  = 8'(MAX_LEN);

    localparam logic [2:0] c_HUNT    = 3'd0;
    localparam logic [2:0] c_LEN     = 3'd1;
    localparam logic [2:0] c_PAYLOAD = 3'd2;
    localparam logic [2:0] c_CHECK   = 3'd3;
    localparam logic [2:0] c_EMIT    = 3'd4;

    localparam logic [1:0] c_ERR_CSUM = 2'd1;
    localparam logic [1:0] c_ERR_LEN  = 2'd2;
    localparam logic [1:0] c_ERR_TMO  = 2'd3;

    logic [2:0]      r_state;
    logic [7:0]      r_len;
    logic [7:0]      r_sum;
    logic [7:0]      r_wr_ptr;
    logic [7:0]      r_rd_ptr;
    logic [c_TW-1:0] r_tmo;
    logic [7:0]      r_mem [0:MAX_LEN-1];
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_last;
    logic            r_frame_done;
    logic            r_frame_err;
    logic [1:0]      r_err_code;

    logic       w_in_frame;
    logic       w_timeout;
    logic [7:0] w_sum_next;
    logic [7:0] w_rd_next;
    logic       w_accept;
    logic       w_mem_wr;

    assign w_in_frame = (r_state == c_LEN) || (r_state == c_PAYLOAD) || (r_state == c_CHECK);
    assign w_timeout  = w_in_frame && !valid_in && (r_tmo == c_TMO_LAST);
    assign w_sum_next = r_sum + data_in;
    assign w_rd_next  = r_rd_ptr + 8'd1;
    assign w_accept   = r_out_valid && out_ready;
    assign w_mem_wr   = (r_state == c_PAYLOAD) && valid_in;

    // Payload storage has no reset; pointers alone define what is valid.
    always_ff @(posedge clk_in) begin
        if (!rst_in && w_mem_wr) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= c_HUNT;
            r_len        <= 8'd0;
            r_sum        <= 8'd0;
            r_wr_ptr     <= 8'd0;
            r_rd_ptr     <= 8'd0;
            r_tmo        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'd0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;

            if (!w_in_frame || valid_in) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_err_code  <= c_ERR_TMO;
                r_state     <= c_HUNT;
            end else begin
                case (r_state)
                    c_HUNT: begin
                        if (valid_in && (data_in == SYNC_BYTE)) begin
                            r_state <= c_LEN;
                        end
                    end
                    c_LEN: begin
                        if (valid_in) begin
                            r_len    <= data_in;
                            r_sum    <= data_in;
                            r_wr_ptr <= 8'd0;
                            if (data_in > c_MAX_LEN) begin
                                r_frame_err <= 1'b1;
                                r_err_code  <= c_ERR_LEN;
                                r_state     <= c_HUNT;
                            end else if (data_in == 8'd0) begin
                                r_state <= c_CHECK;
                            end else begin
                                r_state <= c_PAYLOAD;
                            end
                        end
                    end
                    c_PAYLOAD: begin
                        if (valid_in) begin
                            r_wr_ptr <= r_wr_ptr + 8'd1;
                            r_sum    <= w_sum_next;
                            if (r_wr_ptr == (r_len - 8'd1)) begin
                                r_state <= c_CHECK;
                            end
                        end
                    end
                    c_CHECK: begin
                        if (valid_in) begin
                            if (w_sum_next != 8'd0) begin
                                r_frame_err <= 1'b1;
                                r_err_code  <= c_ERR_CSUM;
                                r_state     <= c_HUNT;
                            end else if (r_len == 8'd0) begin
                                r_frame_done <= 1'b1;
                                r_state      <= c_HUNT;
                            end else begin
                                // First byte is presented straight from the check-byte cycle.
                                r_rd_ptr    <= 8'd0;
                                r_out_valid <= 1'b1;
                                r_out_data  <= r_mem[0];
                                r_out_last  <= (r_len == 8'd1);
                                r_state     <= c_EMIT;
                            end
                        end
                    end
                    c_EMIT: begin
                        if (w_accept) begin
                            if (r_out_last) begin
                                r_out_valid  <= 1'b0;
                                r_out_last   <= 1'b0;
                                r_frame_done <= 1'b1;
                                r_state      <= c_HUNT;
                            end else begin
                                r_rd_ptr   <= w_rd_next;
                                r_out_data <= r_mem[w_rd_next[c_AW-1:0]];
                                r_out_last <= (w_rd_next == (r_len - 8'd1));
                            end
                        end
                    end
                    default: begin
                        r_state <= c_HUNT;
                    end
                endcase
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire
